// File: rtl/mux_nway_rr.sv
`default_nettype none
// ============================================================================
// Module      : mux_nway_rr
// Description : N-channel, WIDTH-bit arbitrating multiplexer with one
//               registered output slot and valid/ready handshakes on every
//               channel. Selection is either an explicit index (fixed mode)
//               or work-conserving round-robin (rr mode).
// Ports       : clk        - rising-edge clock
//               reset      - asynchronous, active-high reset
//               in_data    - flat input bus, channel k at [k*WIDTH +: WIDTH]
//               in_valid   - per-channel valid
//               in_ready   - per-channel ready (one-hot or zero)
//               sel        - channel index used in fixed mode
//               rr_mode    - 0 = fixed (sel), 1 = round-robin
//               out_data   - registered output word
//               out_chan   - channel index the output word came from
//               out_valid  - output word valid
//               out_ready  - sink ready
// Revision    : 1.0 - initial release
// ============================================================================
module mux_nway_rr #(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      rr_mode,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [SEL_W-1:0] c_last_chan = SEL_W'(CHANNELS - 1);

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_chan_q,  out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;

  logic             slot_free;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;

  assign slot_free = ~out_valid_q | out_ready;

  // Grant selection. The round-robin scan runs in two passes so every index
  // is a loop constant: the second pass (channels at or above ptr) overrides
  // the first (channels below ptr), and within each pass the lowest index
  // wins because the loops count downwards.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!rr_mode) begin
      // sel values >= CHANNELS never match a loop index, so they grant nothing.
      for (int k = 0; k < CHANNELS; k++) begin
        if (sel == SEL_W'(k) && in_valid[k]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(k);
        end
      end
    end else begin
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        if (in_valid[k] && (SEL_W'(k) < ptr_q)) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(k);
        end
      end
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        if (in_valid[k] && (SEL_W'(k) >= ptr_q)) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(k);
        end
      end
    end
  end

  // Only the granted channel's word reaches the output register, so unknowns
  // on other channels cannot leak through.
  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant_idx == SEL_W'(k)) begin
        grant_data  = in_data[k*WIDTH +: WIDTH];
        in_ready[k] = slot_free & grant_vld;
      end
    end
  end

  // A grant implies the granted channel is valid, so a free slot plus a grant
  // is exactly a handshake on that channel.
  assign xfer = slot_free & grant_vld;

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (slot_free) begin
      out_valid_d = xfer;
    end
    if (xfer) begin
      out_data_d = grant_data;
      out_chan_d = grant_idx;
      if (rr_mode) begin
        ptr_d = (grant_idx == c_last_chan) ? '0 : grant_idx + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_nway_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_nway_rr
// Description : Self-checking bench for mux_nway_rr. An 8-channel instance is
//               exercised by directed scenarios and random traffic against a
//               behavioural model; a 5-channel instance covers out-of-range
//               sel values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_nway_rr;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int SW = 3;
  localparam int N5 = 5;

  logic          clk = 1'b0;
  logic          reset;

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready;
  logic [SW-1:0]  sel;
  logic           rr_mode, out_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_chan;
  logic           out_valid;

  logic [N5*W-1:0] in_data5;
  logic [N5-1:0]   in_valid5, in_ready5;
  logic [SW-1:0]   sel5;
  logic            rr_mode5, out_ready5;
  logic [W-1:0]    out_data5;
  logic [SW-1:0]   out_chan5;
  logic            out_valid5;

  int tests = 0;
  int fails = 0;

  // Behavioural model of the output slot and round-robin pointer.
  bit         m_valid;
  logic [W-1:0] m_data;
  int         m_chan;
  int         m_ptr;

  always #5 clk = ~clk;

  mux_nway_rr #(.WIDTH(W), .CHANNELS(N)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .rr_mode(rr_mode), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_nway_rr #(.WIDTH(W), .CHANNELS(N5)) dut5 (
    .clk(clk), .reset(reset), .in_data(in_data5), .in_valid(in_valid5),
    .in_ready(in_ready5), .sel(sel5), .rr_mode(rr_mode5), .out_data(out_data5),
    .out_chan(out_chan5), .out_valid(out_valid5), .out_ready(out_ready5)
  );

  function automatic int grant_of();
    if (!rr_mode) return in_valid[sel] ? int'(sel) : -1;
    for (int i = 0; i < N; i++) begin
      if (in_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] one = 1;
    int g = grant_of();
    if ((!m_valid || out_ready) && g >= 0) return one << g;
    return '0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_chan = 0; m_ptr = 0;
  endtask

  // Advance one clock and apply the handshake rules to the model.
  task automatic tick();
    int g = grant_of();
    bit free = !m_valid || out_ready;
    logic [W-1:0] d = (g >= 0) ? in_data[g*W +: W] : '0;
    bit rr = rr_mode;
    @(posedge clk);
    if (free) begin
      if (g >= 0) begin
        m_valid = 1; m_data = d; m_chan = g;
        if (rr) m_ptr = (g + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic rand_data();
    for (int k = 0; k < N; k++) in_data[k*W +: W] = W'($urandom);
  endtask

  task automatic test_reset();
    reset = 1; in_data = '0; in_valid = '0; sel = '0; rr_mode = 0; out_ready = 1;
    in_data5 = '0; in_valid5 = '0; sel5 = '0; rr_mode5 = 0; out_ready5 = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({out_valid, out_data, out_chan} !== {1'b0, 16'h0, 3'd0}) begin
      fails++; $display("FAIL reset_out: got v=%b d=%h c=%0d exp 0/0/0", out_valid, out_data, out_chan);
    end
    tests++;
    if (in_ready !== 8'h00 || in_ready5 !== 5'h00 || out_valid5 !== 1'b0) begin
      fails++; $display("FAIL reset_ready: got %h/%h v5=%b exp 0/0/0", in_ready, in_ready5, out_valid5);
    end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_fixed();
    rr_mode = 0; sel = 3'd5; in_valid = 8'hFF; out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      rand_data();
      in_data[5*W +: W] = 16'h1234;
      #1;
      tests++;
      if (in_ready !== 8'h20) begin
        fails++; $display("FAIL fixed_ready[%0d]: got %h exp 20", i, in_ready);
      end
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_chan !== 3'd5) begin
        fails++; $display("FAIL fixed_out[%0d]: got v=%b d=%h c=%0d exp 1/1234/5", i, out_valid, out_data, out_chan);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rr_sweep();
    logic [N-1:0] one = 1;
    rr_mode = 1; in_valid = 8'hFF; out_ready = 1;
    for (int i = 0; i < 9; i++) begin
      rand_data();
      #1;
      tests++;
      if (in_ready !== (one << (i % N))) begin
        fails++; $display("FAIL rr_sweep_ready[%0d]: got %h exp %h", i, in_ready, one << (i % N));
      end
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_chan !== SW'(i % N) || out_data !== m_data) begin
        fails++; $display("FAIL rr_sweep_out[%0d]: got c=%0d d=%h exp c=%0d d=%h", i, out_chan, out_data, i % N, m_data);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap_skip();
    int exp_seq[3] = '{7, 0, 7};
    rr_mode = 1; in_valid = 8'h81; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      #1;
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_chan !== SW'(exp_seq[i])) begin
        fails++; $display("FAIL wrap_skip[%0d]: got c=%0d v=%b exp c=%0d", i, out_chan, out_valid, exp_seq[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] held, fresh;
    rr_mode = 0; sel = 3'd3; in_valid = 8'hFF; out_ready = 1;
    rand_data();
    #1;
    tick();
    held = out_data;
    @(negedge clk);
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      #1;
      tests++;
      if (in_ready !== 8'h00) begin
        fails++; $display("FAIL stall_ready[%0d]: got %h exp 00", i, in_ready);
      end
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== held || out_chan !== 3'd3) begin
        fails++; $display("FAIL stall_hold[%0d]: got v=%b d=%h c=%0d exp 1/%h/3", i, out_valid, out_data, out_chan, held);
      end
      @(negedge clk);
    end
    out_ready = 1;
    rand_data();
    fresh = ~held;
    in_data[3*W +: W] = fresh;
    #1;
    tests++;
    if (in_ready !== 8'h08) begin
      fails++; $display("FAIL stall_release_ready: got %h exp 08", in_ready);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_data !== fresh || out_chan !== 3'd3) begin
      fails++; $display("FAIL stall_refill: got v=%b d=%h c=%0d exp 1/%h/3", out_valid, out_data, out_chan, fresh);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rr_mode   = ($urandom_range(0, 2) != 0);
      sel       = SW'($urandom);
      in_valid  = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      #1;
      tests++;
      if (in_ready !== exp_ready()) begin
        fails++; $display("FAIL random_ready[%0d]: got %h exp %h", i, in_ready, exp_ready());
      end
      tick();
      tests++;
      if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_chan !== SW'(m_chan)))) begin
        fails++; $display("FAIL random_out[%0d]: got v=%b d=%h c=%0d exp v=%b d=%h c=%0d",
                          i, out_valid, out_data, out_chan, m_valid, m_data, m_chan);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_bad_sel();
    rr_mode5 = 0; sel5 = 3'd2; in_valid5 = 5'h1F; out_ready5 = 1;
    for (int k = 0; k < N5; k++) in_data5[k*W +: W] = W'($urandom);
    in_data5[2*W +: W] = 16'hBEEF;
    #1;
    tests++;
    if (in_ready5 !== 5'b00100) begin
      fails++; $display("FAIL bad_sel_prep_ready: got %b exp 00100", in_ready5);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid5 !== 1'b1 || out_data5 !== 16'hBEEF || out_chan5 !== 3'd2) begin
      fails++; $display("FAIL bad_sel_prep_out: got v=%b d=%h c=%0d exp 1/beef/2", out_valid5, out_data5, out_chan5);
    end
    @(negedge clk);
    sel5 = 3'd6;
    #1;
    tests++;
    if (in_ready5 !== 5'b00000) begin
      fails++; $display("FAIL bad_sel6_ready: got %b exp 00000", in_ready5);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid5 !== 1'b0) begin
      fails++; $display("FAIL bad_sel6_valid: got %b exp 0", out_valid5);
    end
    @(negedge clk);
    sel5 = 3'd5;
    #1;
    tests++;
    if (in_ready5 !== 5'b00000) begin
      fails++; $display("FAIL bad_sel5_ready: got %b exp 00000", in_ready5);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    rr_mode = 1; in_valid = 8'hFF; out_ready = 1;
    rand_data();
    #1;
    tick();
    #2;
    reset = 1;
    model_reset();
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_chan !== 3'd0) begin
      fails++; $display("FAIL async_reset_out: got v=%b d=%h c=%0d exp 0/0/0", out_valid, out_data, out_chan);
    end
    tests++;
    if (in_ready !== 8'h01) begin
      fails++; $display("FAIL async_reset_ptr: got ready %h exp 01", in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    rand_data();
    #1;
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_chan !== 3'd0 || out_data !== m_data) begin
      fails++; $display("FAIL async_reset_first_grant: got v=%b c=%0d d=%h exp 1/0/%h", out_valid, out_chan, out_data, m_data);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_sweep();
    test_wrap_skip();
    test_stall();
    test_random();
    test_bad_sel();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
